// File: rtl/l2_cacheline_adapter.sv
// Line-to-burst adapter between the L2/EWB line interface and the physical-memory beat port.
// Optional build macro L2_ADAPTER_PERF_CNT_EN adds hierarchical-only performance counters.
module l2_cacheline_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic               read_o,
  output logic               write_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'((LINE_W / 8) - 1));

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wbuf_q, wbuf_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               resp_q, resp_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state, beat counter and datapath for the line transfer FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          state_d = WRITE;
          addr_d  = address_i & ADDR_MASK;
          wbuf_d  = line_i;
          burst_d = line_i[BURST_W-1:0];
        end else if (read_i) begin
          state_d = READ;
          addr_d  = address_i & ADDR_MASK;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[int'(cnt_q) * BURST_W +: BURST_W] = burst_i;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        // burst_o is pre-loaded with the next slice so it tracks cnt without a mux on the output.
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
            burst_d = wbuf_q[int'(cnt_inc) * BURST_W +: BURST_W];
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign resp_o    = resp_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign address_o = addr_q;
  assign burst_o   = burst_q;

`ifdef L2_ADAPTER_PERF_CNT_EN
  int num_line_reads;
  int num_line_writes;
  int num_mem_wait_cycles;

  // Transfer and memory-stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_line_reads      <= 0;
      num_line_writes     <= 0;
      num_mem_wait_cycles <= 0;
    end else begin
      if (state_q == IDLE && state_d == READ) begin
        num_line_reads <= num_line_reads + 1;
      end
      if (state_q == IDLE && state_d == WRITE) begin
        num_line_writes <= num_line_writes + 1;
      end
      if ((state_q == READ || state_q == WRITE) && !resp_i) begin
        num_mem_wait_cycles <= num_mem_wait_cycles + 1;
      end
    end
  end
`else
  // Counters are not built; datapath behaviour is unchanged.
`endif

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// Directed, table-driven bench for l2_cacheline_adapter with hand-written multi-cycle sequences.
module tb_l2_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o, burst_i;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  l2_cacheline_adapter dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .address_i(address_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .read_o(read_o), .write_o(write_o),
    .address_o(address_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  typedef struct {
    logic         rst, rd, wr;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [63:0]  burst;
    logic         resp;
    logic         e_rd, e_wr, e_resp;
    logic [31:0]  e_addr;
    logic         chk_burst;
    logic [63:0]  e_burst;
    logic         chk_line;
    logic [255:0] e_line;
  } vec_t;

  vec_t vq[$];

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [255:0] L1 = {B4, B3, B2, B1};
  localparam logic [255:0] LW = {64'd3, 64'd2, 64'd1, 64'd0};
  localparam logic [63:0] A1 = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] A2 = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] A3 = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] A4 = 64'hDDDD_0000_0000_0004;
  localparam logic [255:0] LA = {A4, A3, A2, A1};
  localparam logic [63:0] E1 = 64'hE1E1_E1E1_0000_0001;
  localparam logic [63:0] E2 = 64'hE2E2_E2E2_0000_0002;
  localparam logic [63:0] E3 = 64'hE3E3_E3E3_0000_0003;
  localparam logic [63:0] E4 = 64'hE4E4_E4E4_0000_0004;
  localparam logic [255:0] LE = {E4, E3, E2, E1};
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  function automatic void add(
    input logic r, input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] l,
    input logic [63:0] b, input logic rs, input logic erd, input logic ewr, input logic ersp,
    input logic [31:0] ea, input logic cb, input logic [63:0] eb, input logic cl,
    input logic [255:0] el);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.line = l; v.burst = b; v.resp = rs;
    v.e_rd = erd; v.e_wr = ewr; v.e_resp = ersp; v.e_addr = ea;
    v.chk_burst = cb; v.e_burst = eb; v.chk_line = cl; v.e_line = el;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [255:0] l, input logic [63:0] b, input logic rs);
    rst = r; read_i = rd; write_i = wr; address_i = a; line_i = l; burst_i = b; resp_i = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] fv[4];
    logic [63:0] gv[4];
    logic [63:0] hv[4];
    logic        pat[7];
    int          k;
`ifdef L2_ADAPTER_PERF_CNT_EN
    int          w0;
`endif
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = 32'h0; line_i = '0;
    burst_i = 64'h0; resp_i = 1'b0;

    // reset, scenario 1 (read), scenario 2 (write), scenario 3 (write priority then read)
    add(1'b1, 1'b0, 1'b0, 32'h0,      '0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 64'h0, 1'b1, '0);
    add(1'b0, 1'b1, 1'b0, 32'h1234,   '0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1220,   1'b0, 64'h0, 1'b1, '0);
    add(1'b0, 1'b0, 1'b0, 32'h1234,   '0, B1,    1'b1, 1'b1, 1'b0, 1'b0, 32'h1220,   1'b0, 64'h0, 1'b0, '0);
    add(1'b0, 1'b0, 1'b0, 32'h1234,   '0, B2,    1'b1, 1'b1, 1'b0, 1'b0, 32'h1220,   1'b0, 64'h0, 1'b0, '0);
    add(1'b0, 1'b0, 1'b0, 32'h1234,   '0, B3,    1'b1, 1'b1, 1'b0, 1'b0, 32'h1220,   1'b0, 64'h0, 1'b0, '0);
    add(1'b0, 1'b0, 1'b0, 32'h1234,   '0, B4,    1'b1, 1'b0, 1'b0, 1'b1, 32'h1220,   1'b0, 64'h0, 1'b1, L1);
    add(1'b0, 1'b0, 1'b0, 32'h0,      '0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1220,   1'b0, 64'h0, 1'b1, L1);
    add(1'b0, 1'b0, 1'b1, 32'h4000,   LW, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4000,   1'b1, 64'd0, 1'b1, L1);
    add(1'b0, 1'b0, 1'b0, 32'h9999,   '0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4000,   1'b1, 64'd1, 1'b1, L1);
    add(1'b0, 1'b0, 1'b0, 32'h9999,   '0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4000,   1'b1, 64'd2, 1'b1, L1);
    add(1'b0, 1'b0, 1'b0, 32'h9999,   '0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4000,   1'b1, 64'd3, 1'b1, L1);
    add(1'b0, 1'b0, 1'b0, 32'h9999,   '0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000,   1'b0, 64'h0, 1'b1, L1);
    add(1'b0, 1'b0, 1'b0, 32'h0,      '0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000,   1'b0, 64'h0, 1'b1, L1);
    add(1'b0, 1'b1, 1'b1, 32'h8047,   LA, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8040,   1'b1, A1,    1'b1, L1);
    add(1'b0, 1'b1, 1'b0, 32'h8047,   '0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8040,   1'b1, A2,    1'b1, L1);
    add(1'b0, 1'b1, 1'b0, 32'h8047,   '0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8040,   1'b1, A3,    1'b1, L1);
    add(1'b0, 1'b1, 1'b0, 32'h8047,   '0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8040,   1'b1, A4,    1'b1, L1);
    add(1'b0, 1'b1, 1'b0, 32'h8047,   '0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8040,   1'b0, 64'h0, 1'b1, L1);
    add(1'b0, 1'b1, 1'b0, 32'h8047,   '0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8040,   1'b0, 64'h0, 1'b1, L1);
    add(1'b0, 1'b1, 1'b0, 32'h8047,   '0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8040,   1'b0, 64'h0, 1'b1, L1);
    add(1'b0, 1'b0, 1'b0, 32'h8047,   '0, E1,    1'b1, 1'b1, 1'b0, 1'b0, 32'h8040,   1'b0, 64'h0, 1'b0, '0);
    add(1'b0, 1'b0, 1'b0, 32'h8047,   '0, E2,    1'b1, 1'b1, 1'b0, 1'b0, 32'h8040,   1'b0, 64'h0, 1'b0, '0);
    add(1'b0, 1'b0, 1'b0, 32'h8047,   '0, E3,    1'b1, 1'b1, 1'b0, 1'b0, 32'h8040,   1'b0, 64'h0, 1'b0, '0);
    add(1'b0, 1'b0, 1'b0, 32'h8047,   '0, E4,    1'b1, 1'b0, 1'b0, 1'b1, 32'h8040,   1'b0, 64'h0, 1'b1, LE);
    add(1'b0, 1'b0, 1'b0, 32'h0,      '0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8040,   1'b0, 64'h0, 1'b1, LE);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].rd, vq[i].wr, vq[i].addr, vq[i].line, vq[i].burst, vq[i].resp);
      chk($sformatf("row%0d read_o", i),    256'(read_o),    256'(vq[i].e_rd));
      chk($sformatf("row%0d write_o", i),   256'(write_o),   256'(vq[i].e_wr));
      chk($sformatf("row%0d resp_o", i),    256'(resp_o),    256'(vq[i].e_resp));
      chk($sformatf("row%0d address_o", i), 256'(address_o), 256'(vq[i].e_addr));
      if (vq[i].chk_burst) chk($sformatf("row%0d burst_o", i), 256'(burst_o), 256'(vq[i].e_burst));
      if (vq[i].chk_line)  chk($sformatf("row%0d line_o", i),  line_o, vq[i].e_line);
    end

    // scenario 4: read with memory gaps 1,0,0,1,0,1,1
    for (int i = 0; i < 4; i++) fv[i] = 64'hF000_0000_0000_0000 | 64'(i + 1);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b0; pat[5] = 1'b1; pat[6] = 1'b1;
`ifdef L2_ADAPTER_PERF_CNT_EN
    w0 = dut.num_mem_wait_cycles;
`endif
    step(1'b0, 1'b1, 1'b0, 32'h3010, '0, 64'h0, 1'b0);
    chk("gap start read_o", 256'(read_o), 256'(1'b1));
    chk("gap address_o", 256'(address_o), 256'(32'h3000));
    k = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h3010, '0, pat[i] ? fv[k] : JUNK, pat[i]);
      if (pat[i]) k++;
      if (i < 6) begin
        chk($sformatf("gap%0d read_o", i), 256'(read_o), 256'(1'b1));
        chk($sformatf("gap%0d resp_o", i), 256'(resp_o), 256'(1'b0));
      end else begin
        chk("gap done read_o", 256'(read_o), 256'(1'b0));
        chk("gap done resp_o", 256'(resp_o), 256'(1'b1));
        chk("gap line_o", line_o, {fv[3], fv[2], fv[1], fv[0]});
      end
    end
`ifdef L2_ADAPTER_PERF_CNT_EN
    chk("perf wait cycles", 256'(dut.num_mem_wait_cycles - w0), 256'(3));
`endif
    step(1'b0, 1'b0, 1'b0, 32'h0, '0, 64'h0, 1'b0);
    chk("gap idle resp_o", 256'(resp_o), 256'(1'b0));

    // scenario 5: reset after two write beats, then a clean read
    step(1'b0, 1'b0, 1'b1, 32'h5000, LW, 64'h0, 1'b0);
    chk("rst wr write_o", 256'(write_o), 256'(1'b1));
    step(1'b0, 1'b0, 1'b0, 32'h5000, '0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h5000, '0, 64'h0, 1'b1);
    chk("rst wr burst_o", 256'(burst_o), 256'(64'd2));
    step(1'b1, 1'b0, 1'b0, 32'h5000, '0, 64'h0, 1'b1);
    chk("rst write_o", 256'(write_o), 256'(1'b0));
    chk("rst resp_o", 256'(resp_o), 256'(1'b0));
    chk("rst address_o", 256'(address_o), 256'(32'h0));
    chk("rst burst_o", 256'(burst_o), 256'(64'h0));
    chk("rst line_o", line_o, '0);
    chk("rst cnt", 256'(dut.cnt_q), 256'(0));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, 64'h0, 1'b1);
      chk($sformatf("post rst%0d resp_o", i), 256'(resp_o), 256'(1'b0));
    end
    for (int i = 0; i < 4; i++) gv[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    step(1'b0, 1'b1, 1'b0, 32'h6000, '0, 64'h0, 1'b0);
    chk("post rst read_o", 256'(read_o), 256'(1'b1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h6000, '0, gv[i], 1'b1);
      chk($sformatf("post rst beat%0d resp_o", i), 256'(resp_o), 256'(i == 3));
    end
    chk("post rst line_o", line_o, {gv[3], gv[2], gv[1], gv[0]});
    step(1'b0, 1'b0, 1'b0, 32'h0, '0, 64'h0, 1'b0);

    // scenario 6: resp_i in IDLE is ignored; read_i dropped mid-read still completes
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, '0, JUNK, 1'b1);
      chk($sformatf("idle resp%0d read_o", i), 256'(read_o), 256'(1'b0));
      chk($sformatf("idle resp%0d resp_o", i), 256'(resp_o), 256'(1'b0));
      chk($sformatf("idle resp%0d line_o", i), line_o, {gv[3], gv[2], gv[1], gv[0]});
      chk($sformatf("idle resp%0d address_o", i), 256'(address_o), 256'(32'h6000));
    end
    for (int i = 0; i < 4; i++) hv[i] = 64'h5A5A_0000_0000_0010 | 64'(i);
    step(1'b0, 1'b1, 1'b0, 32'h7000, '0, 64'h0, 1'b0);
    chk("drop read_o", 256'(read_o), 256'(1'b1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, '1, hv[i], 1'b1);
      chk($sformatf("drop beat%0d resp_o", i), 256'(resp_o), 256'(i == 3));
      chk($sformatf("drop beat%0d address_o", i), 256'(address_o), 256'(32'h7000));
    end
    chk("drop line_o", line_o, {hv[3], hv[2], hv[1], hv[0]});
    step(1'b0, 1'b0, 1'b0, 32'h0, '0, 64'h0, 1'b0);
    chk("drop idle resp_o", 256'(resp_o), 256'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
